mont_expo_io: RTL



---
 rtl/mont_expo_io_if.sv | 22 ++
 rtl/mont_expo_io.sv | 124 ++++++++++++
 2 files changed

// File: rtl/mont_expo_io_if.sv
// Host-side word streams of mont_expo_io: input words toward the block, result words back.
// master = host side, slave = mont_expo_io side.
interface mont_expo_io_if #(
    parameter int W = 32
);
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/mont_expo_io.sv
// Word-serial host front end for the 192-bit P-192 Montgomery exponentiator.
// Optional feature: define BASE_REDUCE_EN to reduce the base mod M before it is handed over.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_LOAD    | accept 6 base words then 6 exponent words, LSW first
// S_REDUCE  | register exp_x / exp_y from the assembled operands
// S_START   | hold exp_start until exp_done is seen low
// S_WAIT    | exponentiator running, wait for exp_done high
// S_CAPTURE | register exp_z into the result register
// S_UNLOAD  | stream the 6 result words, LSW first
module mont_expo_io #(
    parameter int K  = 192,
    parameter int W  = 32,
    parameter int NW = 6
) (
    input  logic          clk,
    input  logic          reset,
    mont_expo_io_if.slave host,
    output logic          busy,
    output logic [K-1:0]  exp_x,
    output logic [K-1:0]  exp_y,
    output logic          exp_start,
    input  logic [K-1:0]  exp_z,
    input  logic          exp_done
);

    typedef enum logic [2:0] {
        S_LOAD, S_REDUCE, S_START, S_WAIT, S_CAPTURE, S_UNLOAD
    } state_t;

    localparam logic [3:0] LAST_IN  = 4'(2 * NW - 1);
    localparam logic [2:0] LAST_OUT = 3'(NW - 1);

    state_t       state, next_state;
    logic [3:0]   cnt;
    logic [2:0]   ocnt;
    logic [K-1:0] base, expo, result;
    logic [K-1:0] base_sel;
    logic         in_ready_c, out_valid_c;

`ifdef BASE_REDUCE_EN
    localparam logic [K-1:0] M     = 192'hffffffff_ffffffff_ffffffff_fffffffe_ffffffff_ffffffff;
    localparam logic [K:0]   M_NEG = {1'b1, {K{1'b0}}} - {1'b0, M};

    // base < 2^K < 2M, so adding 2^K - M and checking the carry is a full conditional subtract
    logic [K:0] red_sum;
    assign red_sum  = {1'b0, base} + M_NEG;
    assign base_sel = red_sum[K] ? red_sum[K-1:0] : base;
`else
    assign base_sel = base;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_LOAD;
        else        state <= next_state;
    end

    always_comb begin
        next_state  = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        exp_start   = 1'b0;
        busy        = 1'b0;
        case (state)
            S_LOAD: begin
                in_ready_c = 1'b1;
                if (host.in_valid && cnt == LAST_IN) next_state = S_REDUCE;
            end
            S_REDUCE: begin
                busy       = 1'b1;
                next_state = S_START;
            end
            S_START: begin
                busy      = 1'b1;
                exp_start = 1'b1;
                if (!exp_done) next_state = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (exp_done) next_state = S_CAPTURE;
            end
            S_CAPTURE: begin
                busy       = 1'b1;
                next_state = S_UNLOAD;
            end
            S_UNLOAD: begin
                out_valid_c = 1'b1;
                if (host.out_ready && ocnt == LAST_OUT) next_state = S_LOAD;
            end
            default: next_state = S_LOAD;
        endcase
    end

    assign host.in_ready  = in_ready_c;
    assign host.out_valid = out_valid_c;
    assign host.out_data  = (state == S_UNLOAD) ? result[int'(ocnt) * W +: W] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            ocnt   <= '0;
            base   <= '0;
            expo   <= '0;
            result <= '0;
            exp_x  <= '0;
            exp_y  <= '0;
        end else begin
            if (state == S_LOAD && host.in_valid) begin
                if (cnt < 4'(NW)) base[int'(cnt) * W +: W] <= host.in_data;
                else              expo[(int'(cnt) - NW) * W +: W] <= host.in_data;
                cnt <= (cnt == LAST_IN) ? 4'd0 : cnt + 4'd1;
            end
            if (state == S_REDUCE) begin
                exp_x <= expo;
                exp_y <= base_sel;
            end
            if (state == S_CAPTURE) result <= exp_z;
            if (state == S_UNLOAD && host.out_ready)
                ocnt <= (ocnt == LAST_OUT) ? 3'd0 : ocnt + 3'd1;
        end
    end

endmodule
